// File: rtl/fps_regfile_pkg.sv
// Shared constants for the FPS config register file.
// Defaults, address map and status bit positions.
package fps_regfile_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 8;
  localparam int NUMREGS_DEF    = 9;
  localparam int NUM_STATUS_DEF = 2;

  localparam int CFG_BASE    = 0;
  localparam int STATUS_BASE = CFG_BASE + NUMREGS_DEF;
  localparam int STATUS0     = STATUS_BASE;
  localparam int STATUS1     = STATUS_BASE + 1;
  localparam int ADDR_END    = STATUS_BASE + NUM_STATUS_DEF;

  localparam logic [NUMREGS_DEF*DATA_W_DEF-1:0] RST_VEC_DEF = '0;

  localparam int STS0_PLL_UNLOCK = 0;
  localparam int STS0_ADC_OVR    = 1;
  localparam int STS0_BIAS_FAULT = 2;
  localparam int STS1_FIFO_OVF   = 0;
  localparam int STS1_FIFO_UNF   = 1;

endpackage

// File: rtl/status_sticky_reg.sv
// One sticky status register: level set, write-1-to-clear.
// A set and a clear on the same bit in one cycle leaves it set.
module status_sticky_reg
  import fps_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] set,
  input  logic [DATA_W-1:0] clr,
  output logic [DATA_W-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value <= '0;
    else value <= (value & ~clr) | set;
  end

endmodule

// File: rtl/cfg_regfile_shadow.sv
// Staged config registers with atomic apply to the active outputs,
// sticky status registers above the config space, registered reads.
module cfg_regfile_shadow
  import fps_regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUMREGS    = NUMREGS_DEF,
  parameter int NUM_STATUS = NUM_STATUS_DEF,
  parameter logic [NUMREGS*DATA_W-1:0] RESET_VALUE =
    (NUMREGS*DATA_W)'(RST_VEC_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [DATA_W-1:0] config_bits [NUMREGS],
  input  logic              write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] write_mask,
  input  logic              read,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              read_sel,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic              apply,
  output logic              cfg_updated,
  input  logic [DATA_W-1:0] status_set [NUM_STATUS],
  output logic              addr_err
);

  if ((64'(NUMREGS) + 64'(NUM_STATUS)) > (64'd1 << ADDR_W)) begin : g_chk
    $error("register map does not fit in ADDR_W");
  end

  // One extra bit so the map size itself is representable.
  localparam logic [ADDR_W:0] END_A =
    (ADDR_W+1)'(NUMREGS + NUM_STATUS);

  logic [DATA_W-1:0] staging [NUMREGS];
  logic [DATA_W-1:0] sts [NUM_STATUS];
  logic [DATA_W-1:0] rd_next;
  logic              wr_oor;
  logic              rd_oor;

  assign wr_oor = {1'b0, write_addr} >= END_A;
  assign rd_oor = {1'b0, read_addr} >= END_A;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMREGS; i++) begin
        staging[i]     <= RESET_VALUE[i*DATA_W +: DATA_W];
        config_bits[i] <= RESET_VALUE[i*DATA_W +: DATA_W];
      end
    end else begin
      for (int i = 0; i < NUMREGS; i++) begin
        if (write && write_addr == ADDR_W'(i)) begin
          staging[i] <= (staging[i] & ~write_mask)
                      | (write_data & write_mask);
        end
        if (apply) config_bits[i] <= staging[i];
      end
    end
  end

  for (genvar j = 0; j < NUM_STATUS; j++) begin : g_sts
    logic [DATA_W-1:0] clr;
    assign clr = (write && write_addr == ADDR_W'(NUMREGS + j))
               ? (write_data & write_mask) : '0;
    status_sticky_reg #(.DATA_W(DATA_W)) u_sts (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (status_set[j]),
      .clr     (clr),
      .value   (sts[j])
    );
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUMREGS; i++) begin
      if (read_addr == ADDR_W'(i)) begin
        rd_next = read_sel ? config_bits[i] : staging[i];
      end
    end
    for (int j = 0; j < NUM_STATUS; j++) begin
      if (read_addr == ADDR_W'(NUMREGS + j)) rd_next = sts[j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data   <= '0;
      read_valid  <= 1'b0;
      cfg_updated <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      read_valid  <= read;
      cfg_updated <= apply;
      if (read) read_data <= rd_next;
      if ((write && wr_oor) || (read && rd_oor)) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cfg_regfile_shadow.sv
// Directed bench for cfg_regfile_shadow with a behavioural model
// checked every cycle plus literal spot checks.
module tb_cfg_regfile_shadow;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 9;
  localparam int NS = 2;
  localparam logic [NR*DW-1:0] RV = 72'h000000000000_30115A;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] config_bits [NR];
  logic          write = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] write_mask = '0;
  logic          read = 1'b0;
  logic [AW-1:0] read_addr = '0;
  logic          read_sel = 1'b0;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          apply = 1'b0;
  logic          cfg_updated;
  logic [DW-1:0] status_set [NS];
  logic          addr_err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  cfg_regfile_shadow #(
    .DATA_W(DW), .ADDR_W(AW), .NUMREGS(NR),
    .NUM_STATUS(NS), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .config_bits(config_bits),
    .write(write), .write_addr(write_addr),
    .write_data(write_data), .write_mask(write_mask),
    .read(read), .read_addr(read_addr), .read_sel(read_sel),
    .read_data(read_data), .read_valid(read_valid),
    .apply(apply), .cfg_updated(cfg_updated),
    .status_set(status_set), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: per-operation rules on plain arrays.
  logic [DW-1:0] m_stg [NR];
  logic [DW-1:0] m_cfg [NR];
  logic [DW-1:0] m_sts [NS];
  logic [DW-1:0] m_rd;
  logic m_rv, m_upd, m_err;

  always @(posedge clk or negedge reset_n) begin
    logic [DW-1:0] n_stg [NR];
    logic [DW-1:0] n_cfg [NR];
    logic [DW-1:0] n_sts [NS];
    logic n_err;
    int wa, ra;
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) begin
        m_stg[i] = RV[i*DW +: DW];
        m_cfg[i] = RV[i*DW +: DW];
      end
      for (int j = 0; j < NS; j++) m_sts[j] = '0;
      m_rd = '0; m_rv = 0; m_upd = 0; m_err = 0;
    end else begin
      n_stg = m_stg; n_cfg = m_cfg; n_sts = m_sts; n_err = m_err;
      wa = int'(write_addr);
      ra = int'(read_addr);
      if (write) begin
        if (wa < NR)
          n_stg[wa] = (m_stg[wa] & ~write_mask) | (write_data & write_mask);
        else if (wa < NR + NS)
          n_sts[wa-NR] = m_sts[wa-NR] & ~(write_data & write_mask);
        else
          n_err = 1;
      end
      for (int j = 0; j < NS; j++) n_sts[j] = n_sts[j] | status_set[j];
      if (apply) n_cfg = m_stg;
      m_upd = apply;
      m_rv = read;
      if (read) begin
        if (ra < NR) m_rd = read_sel ? m_cfg[ra] : m_stg[ra];
        else if (ra < NR + NS) m_rd = m_sts[ra-NR];
        else begin m_rd = '0; n_err = 1; end
      end
      m_stg = n_stg; m_cfg = n_cfg; m_sts = n_sts; m_err = n_err;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NR; i++) chk($sformatf("cfg%0d", i), 32'(config_bits[i]), 32'(m_cfg[i]));
      chk("read_data", 32'(read_data), 32'(m_rd));
      chk("read_valid", 32'(read_valid), 32'(m_rv));
      chk("cfg_updated", 32'(cfg_updated), 32'(m_upd));
      chk("addr_err", 32'(addr_err), 32'(m_err));
    end
  end

  task automatic idle();
    write = 0; read = 0; apply = 0; read_sel = 0;
    write_addr = '0; write_data = '0; write_mask = '0; read_addr = '0;
    status_set[0] = '0; status_set[1] = '0;
  endtask

  // Advance one clock; inputs set before the call are sampled on its edge.
  task automatic cyc();
    @(negedge clk);
    #1 idle();
  endtask

  task automatic wr(input int a, input logic [7:0] d, input logic [7:0] m);
    write = 1; write_addr = AW'(a); write_data = d; write_mask = m;
  endtask

  task automatic rd(input int a, input logic s);
    read = 1; read_addr = AW'(a); read_sel = s;
  endtask

  initial begin
    idle();
    #12 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk("rst cfg0", 32'(config_bits[0]), 32'h5A);
    chk("rst err", 32'(addr_err), 32'h0);

    rd(0, 1); cyc();
    chk("rd0 act", 32'(read_data), 32'h5A);
    chk("rd0 vld", 32'(read_valid), 32'h1);
    chk("model pin stg0", 32'(m_stg[0]), 32'h5A);

    wr(2, 8'hFF, 8'h0F); cyc();
    rd(2, 0); cyc();
    chk("stg2 masked", 32'(read_data), 32'h3F);
    chk("cfg2 pre-apply", 32'(config_bits[2]), 32'h30);
    apply = 1; cyc();
    chk("cfg_updated", 32'(cfg_updated), 32'h1);
    chk("cfg2 applied", 32'(config_bits[2]), 32'h3F);
    cyc();
    chk("cfg_updated drop", 32'(cfg_updated), 32'h0);

    wr(1, 8'hAA, 8'hFF); apply = 1; cyc();
    chk("cfg1 old", 32'(config_bits[1]), 32'h11);
    apply = 1; cyc();
    apply = 1; cyc();
    chk("cfg1 new", 32'(config_bits[1]), 32'hAA);
    chk("b2b upd", 32'(cfg_updated), 32'h1);

    wr(0, 8'h77, 8'hFF); rd(0, 0); cyc();
    chk("wr+rd old", 32'(read_data), 32'h5A);
    apply = 1; rd(0, 1); cyc();
    chk("apply+rd old act", 32'(read_data), 32'h5A);

    status_set[0] = 8'h04; cyc();
    rd(NR, 0); cyc();
    chk("sts set", 32'(read_data), 32'h04);
    wr(NR, 8'h04, 8'hFF); cyc();
    rd(NR, 1); cyc();
    chk("sts clr", 32'(read_data), 32'h00);
    status_set[1] = 8'h81; cyc();
    wr(NR+1, 8'hFF, 8'h01); status_set[1] = 8'h01; cyc();
    rd(NR+1, 0); cyc();
    chk("sts1 set wins", 32'(read_data), 32'h81);
    wr(NR+1, 8'hFF, 8'h80); cyc();
    rd(NR+1, 0); cyc();
    chk("sts1 mask clr", 32'(read_data), 32'h01);
    status_set[0] = 8'h04; wr(NR, 8'h04, 8'hFF); cyc();
    rd(NR, 0); cyc();
    chk("sts same cyc", 32'(read_data), 32'h04);

    wr(NR+NS, 8'hFF, 8'hFF); cyc();
    chk("oor wr err", 32'(addr_err), 32'h1);
    chk("oor wr cfg0", 32'(config_bits[0]), 32'h77);
    wr(8'h89, 8'hFF, 8'hFF); cyc();
    rd(NR+NS, 1); cyc();
    chk("oor rd data", 32'(read_data), 32'h00);
    chk("oor rd vld", 32'(read_valid), 32'h1);
    repeat (3) cyc();
    chk("err holds", 32'(addr_err), 32'h1);

    rd(0, 1); cyc();
    chk("pre-rst rd", 32'(read_data), 32'h77);
    wr(2, 8'h00, 8'hFF); cyc();
    rd(0, 1); wr(1, 8'h00, 8'hFF); apply = 1;
    #2 reset_n = 1'b0;
    #1;
    chk("async cfg0", 32'(config_bits[0]), 32'h5A);
    chk("async cfg2", 32'(config_bits[2]), 32'h30);
    chk("async rdata", 32'(read_data), 32'h00);
    chk("async rvld", 32'(read_valid), 32'h0);
    chk("async upd", 32'(cfg_updated), 32'h0);
    chk("async err", 32'(addr_err), 32'h0);
    cyc();
    reset_n = 1'b1;
    rd(2, 0); cyc();
    chk("stg2 after rst", 32'(read_data), 32'h30);
    rd(NR, 0); cyc();
    chk("sts after rst", 32'(read_data), 32'h00);
    cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_regfile_shadow.md
Name: cfg_regfile_shadow

Overview:
Parametrised configuration register file for the FPS digital core, replacing the fixed 8-bit/256-address config store. The host writes staging registers with a per-bit mask. An apply strobe copies all staging registers into the active config outputs in one clock edge, so analog config changes land atomically. Sticky write-1-to-clear status registers are mapped above the config space, and a registered read port flags out-of-range accesses.

Parameters:
DATA_W, 8, width of each register in bits
ADDR_W, 8, width of the read and write address buses
NUMREGS, 9, number of config registers, at addresses 0..NUMREGS-1
NUM_STATUS, 2, number of sticky status registers, at addresses NUMREGS..NUMREGS+NUM_STATUS-1
RESET_VALUE, all zeros, packed NUMREGS*DATA_W vector of per-register defaults; register i uses bits [i*DATA_W +: DATA_W]

Ports:
clk  in  1  system clock
reset_n  in  1  digital reset; asynchronous assert, active-low
config_bits  out  [DATA_W-1:0] x NUMREGS  active (shadow) config registers
write  in  1  write strobe
write_addr  in  ADDR_W  write address
write_data  in  DATA_W  write data
write_mask  in  DATA_W  per-bit write enable; 1 = update the bit
read  in  1  read strobe
read_addr  in  ADDR_W  read address
read_sel  in  1  0 = read staging register, 1 = read active register (config space only)
read_data  out  DATA_W  registered read data
read_valid  out  1  one-cycle pulse marking valid read_data
apply  in  1  copy all staging registers into config_bits
cfg_updated  out  1  one-cycle pulse, the cycle after an apply is taken
status_set  in  DATA_W x NUM_STATUS  level inputs that set sticky status bits
addr_err  out  1  sticky flag for an out-of-range write or read

Behaviour:
- Reset (asynchronous, reset_n low), applied immediately regardless of clk:
  - staging[i] and config_bits[i] = RESET_VALUE slice i.
  - All status registers = 0.
  - read_data = 0, read_valid = 0, cfg_updated = 0, addr_err = 0.
- Reset asserted mid-operation aborts any pending read and any apply; no partial state survives.
- Config write (write=1, write_addr < NUMREGS):
  - staging[a] <= (staging[a] & ~write_mask) | (write_data & write_mask).
  - config_bits is not affected.
- Status write (NUMREGS <= write_addr < NUMREGS+NUM_STATUS):
  - Write-1-to-clear, gated by write_mask: bits where write_data & write_mask = 1 are cleared.
- Out-of-range write: no register changes; addr_err <= 1.
- Status set: every cycle, status[j] <= status[j] | status_set[j].
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Read (read=1), one-cycle latency: read_data and read_valid are updated on the next edge.
  - Config space: returns staging[a] if read_sel=0, config_bits[a] if read_sel=1.
  - Status space: returns status[j]; read_sel is ignored.
  - Out of range: read_data = 0, read_valid = 1, addr_err <= 1.
  - When read=0: read_valid = 0 and read_data holds its last value.
- addr_err is cleared only by reset.
- Apply (apply=1): config_bits[i] <= staging[i] for all i on the same edge; cfg_updated = 1 on the following cycle.
  - Back-to-back applies give back-to-back cfg_updated pulses.
- Simultaneous events; all reads and copies use pre-edge register values:
  - write + apply in one cycle: apply copies the old staging value. The new write lands in staging only and needs another apply.
  - write + read to the same address in one cycle: read returns the old value.
  - apply + read with read_sel=1 in one cycle: read returns the old active value.
- Address compares use the full ADDR_W bits, so there is no aliasing or wrap-around.
- Elaboration check: NUMREGS + NUM_STATUS <= 2**ADDR_W, otherwise $error.

Decomposition:
- Shared package fps_regfile_pkg holds:
  - default DATA_W and ADDR_W;
  - config and status register address localparams;
  - the RESET_VALUE default vector;
  - status bit-field positions.
- One sub-module, status_sticky_reg: one DATA_W sticky register with set-priority W1C, instantiated NUM_STATUS times.
- All other logic stays in the top module.

Test Plan:
- Reset with RESET_VALUE reg0=0x5A -> staging0 = config_bits[0] = 0x5A; read of addr 0, sel=1 returns 0x5A with read_valid one cycle later.
- Write addr 2, data 0xFF, mask 0x0F, over 0x30 -> staging2 = 0x3F and config_bits[2] stays 0x30 until apply; cfg_updated pulses the cycle after apply, then config_bits[2] = 0x3F.
- Write addr 1 = 0xAA with apply in the same cycle (old staging 0x11) -> config_bits[1] = 0x11; a second apply gives 0xAA.
- status_set[0] = 0x04 for one cycle, then W1C data 0x04 at addr NUMREGS -> status reads 0x04 before the clear and 0x00 after; with set and clear in the same cycle it stays 0x04.
- Write to addr NUMREGS+NUM_STATUS -> no register changes, addr_err = 1; a read there returns 0x00 with read_valid = 1; addr_err holds until reset.
- Assert reset_n low between write strobes and mid-read -> all outputs return to reset values asynchronously, without a clk edge.
